// File: rtl/run_tracker.sv
// Multi-channel high-run tracker: qualifies level runs of at least MIN_RUN samples,
// reports run-active, end-of-run pulse, glitch pulse and captured run length.
module run_tracker #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [NCH-1:0]       din,
  output logic [NCH-1:0]       r,
  output logic [NCH-1:0]       f,
  output logic [NCH-1:0]       glitch,
  output logic [NCH*CNT_W-1:0] len,
  output logic                 any_f
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    LAST = 3'd3,
    DROP = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   MIN_Q   = (CNT_W+1)'(MIN_RUN);

  state_t           state_r     [NCH];
  state_t           state_nxt_s [NCH];
  logic [CNT_W-1:0] cnt_r       [NCH];
  logic [CNT_W-1:0] cnt_nxt_s   [NCH];
  logic [CNT_W:0]   cnt_inc_s   [NCH];
  logic [CNT_W-1:0] len_r       [NCH];
  logic [NCH-1:0]   r_r;
  logic [NCH-1:0]   f_r;
  logic [NCH-1:0]   glitch_r;

  // Per-channel next-state and counter logic; clr falls through to the IDLE/0 defaults
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nxt_s[i] = IDLE;
      cnt_nxt_s[i]   = {CNT_W{1'b0}};
      // one extra bit so the ARM qualification compare cannot wrap
      cnt_inc_s[i]   = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (clr) begin
        state_nxt_s[i] = IDLE;
        cnt_nxt_s[i]   = {CNT_W{1'b0}};
      end else begin
        case (state_r[i])
          IDLE: begin
            if (din[i]) begin
              cnt_nxt_s[i]   = CNT_ONE;
              state_nxt_s[i] = (MIN_RUN == 1) ? RUN : ARM;
            end else begin
              cnt_nxt_s[i]   = {CNT_W{1'b0}};
              state_nxt_s[i] = IDLE;
            end
          end
          ARM: begin
            if (din[i]) begin
              cnt_nxt_s[i]   = cnt_inc_s[i][CNT_W-1:0];
              state_nxt_s[i] = (cnt_inc_s[i] >= MIN_Q) ? RUN : ARM;
            end else begin
              cnt_nxt_s[i]   = cnt_r[i];
              state_nxt_s[i] = DROP;
            end
          end
          RUN: begin
            if (din[i]) begin
              cnt_nxt_s[i]   = (cnt_r[i] == CNT_MAX) ? cnt_r[i] : cnt_inc_s[i][CNT_W-1:0];
              state_nxt_s[i] = RUN;
            end else begin
              cnt_nxt_s[i]   = cnt_r[i];
              state_nxt_s[i] = LAST;
            end
          end
          LAST: begin
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
            state_nxt_s[i] = IDLE;
          end
          DROP: begin
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
            state_nxt_s[i] = IDLE;
          end
          default: begin
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
            state_nxt_s[i] = IDLE;
          end
        endcase
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
    end
  end

  // Output registers, loaded from the state held before the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r      <= {NCH{1'b0}};
      f_r      <= {NCH{1'b0}};
      glitch_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        len_r[i] <= {CNT_W{1'b0}};
      end
    end else if (clr) begin
      r_r      <= {NCH{1'b0}};
      f_r      <= {NCH{1'b0}};
      glitch_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        len_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_r[i]      <= (state_r[i] == RUN);
        f_r[i]      <= (state_r[i] == LAST);
        glitch_r[i] <= (state_r[i] == DROP);
        if (state_r[i] == LAST) begin
          len_r[i] <= cnt_r[i];
        end else begin
          len_r[i] <= len_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_len
    assign len[g*CNT_W +: CNT_W] = len_r[g];
  end

  assign r      = r_r;
  assign f      = f_r;
  assign glitch = glitch_r;
  assign any_f  = |f_r;

endmodule

// File: tb/tb_run_tracker.sv
// Bench for run_tracker: fixed vector table, corner sequences and random stimulus
// checked against a run-level reference model, across three parameter sets.
module tb_run_tracker;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [3:0]  din;

  logic [3:0]  r_a, f_a, g_a, r_b, f_b, g_b, r_c, f_c, g_c;
  logic [31:0] len_a, len_c;
  logic [11:0] len_b;
  logic        any_a, any_b, any_c;

  int vectors = 0;
  int miscompares = 0;

  // instance 0: defaults, 1: CNT_W=3, 2: MIN_RUN=1
  run_tracker #(.NCH(4), .CNT_W(8), .MIN_RUN(2)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .r(r_a), .f(f_a), .glitch(g_a), .len(len_a), .any_f(any_a));
  run_tracker #(.NCH(4), .CNT_W(3), .MIN_RUN(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .r(r_b), .f(f_b), .glitch(g_b), .len(len_b), .any_f(any_b));
  run_tracker #(.NCH(4), .CNT_W(8), .MIN_RUN(1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .r(r_c), .f(f_c), .glitch(g_c), .len(len_c), .any_f(any_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the length of the open high run and a pending run-end report
  int minr [3] = '{2, 2, 1};
  int maxc [3] = '{255, 7, 255};
  int streak [3][4];
  bit endq [3][4];
  bit endg [3][4];
  int endlen [3][4];
  bit er [3][4];
  bit ef [3][4];
  bit eg [3][4];
  int el [3][4];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 4; c++) begin
        streak[i][c] = 0; endq[i][c] = 1'b0; endg[i][c] = 1'b0; endlen[i][c] = 0;
        er[i][c] = 1'b0; ef[i][c] = 1'b0; eg[i][c] = 1'b0; el[i][c] = 0;
      end
  endtask

  task automatic model_edge(input logic [3:0] d, input logic c_in);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 4; c++) begin
        if (c_in) begin
          streak[i][c] = 0; endq[i][c] = 1'b0; endg[i][c] = 1'b0;
          er[i][c] = 1'b0; ef[i][c] = 1'b0; eg[i][c] = 1'b0; el[i][c] = 0;
        end else begin
          er[i][c] = (streak[i][c] >= minr[i]);
          ef[i][c] = endq[i][c];
          eg[i][c] = endg[i][c];
          if (endq[i][c]) el[i][c] = endlen[i][c];
          if (endq[i][c] || endg[i][c]) begin
            endq[i][c] = 1'b0; endg[i][c] = 1'b0; streak[i][c] = 0;
          end else if (d[c]) begin
            streak[i][c]++;
          end else if (streak[i][c] > 0) begin
            if (streak[i][c] >= minr[i]) begin
              endq[i][c] = 1'b1;
              endlen[i][c] = (streak[i][c] > maxc[i]) ? maxc[i] : streak[i][c];
            end else begin
              endg[i][c] = 1'b1;
            end
            streak[i][c] = 0;
          end
        end
      end
  endtask

  function automatic logic [3:0] get_r(input int i);
    case (i)
      0: return r_a;
      1: return r_b;
      default: return r_c;
    endcase
  endfunction

  function automatic logic [3:0] get_f(input int i);
    case (i)
      0: return f_a;
      1: return f_b;
      default: return f_c;
    endcase
  endfunction

  function automatic logic [3:0] get_g(input int i);
    case (i)
      0: return g_a;
      1: return g_b;
      default: return g_c;
    endcase
  endfunction

  function automatic logic get_any(input int i);
    case (i)
      0: return any_a;
      1: return any_b;
      default: return any_c;
    endcase
  endfunction

  function automatic logic [31:0] get_len(input int i, input int c);
    case (i)
      0: return {24'd0, len_a[c*8 +: 8]};
      1: return {29'd0, len_b[c*3 +: 3]};
      default: return {24'd0, len_c[c*8 +: 8]};
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] xr, xf, xg;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        xr[c] = er[i][c]; xf[c] = ef[i][c]; xg[c] = eg[i][c];
        cmp($sformatf("%s len i%0d c%0d", tag, i, c), get_len(i, c), el[i][c]);
      end
      cmp($sformatf("%s r i%0d", tag, i), {28'd0, get_r(i)}, {28'd0, xr});
      cmp($sformatf("%s f i%0d", tag, i), {28'd0, get_f(i)}, {28'd0, xf});
      cmp($sformatf("%s glitch i%0d", tag, i), {28'd0, get_g(i)}, {28'd0, xg});
      cmp($sformatf("%s any_f i%0d", tag, i), {31'd0, get_any(i)}, {31'd0, |xf});
    end
  endtask

  task automatic step(input logic [3:0] d, input logic c_in, input string tag);
    @(negedge clk);
    din = d;
    clr = c_in;
    @(posedge clk);
    #1;
    model_edge(d, c_in);
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0]  din;
    logic        clr;
    logic [3:0]  r;
    logic [3:0]  f;
    logic [3:0]  g;
    logic [31:0] len;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [3:0] lvl;
    logic       c_rand;

    tbl[0]  = '{4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0010, 32'h00000000};
    tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000000};
    tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000000};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000000};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 32'h00000005};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000005};
    tbl[8]  = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000005};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000005};
    tbl[10] = '{4'b1001, 1'b0, 4'b1001, 4'b0000, 4'b0000, 32'h00000005};
    tbl[11] = '{4'b0000, 1'b0, 4'b1001, 4'b0000, 4'b0000, 32'h00000005};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 4'b1001, 4'b0000, 32'h03000003};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h03000003};
    tbl[14] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h03000003};
    tbl[15] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h03000003};
    tbl[16] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};
    tbl[17] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};
    // the single high sample after clr is a new short run, hence this glitch
    tbl[19] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h00000000};
    tbl[20] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000};

    rst = 1'b1;
    clr = 1'b0;
    din = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      step(tbl[k].din, tbl[k].clr, "tbl_model");
      cmp($sformatf("tbl%0d r", k), {28'd0, r_a}, {28'd0, tbl[k].r});
      cmp($sformatf("tbl%0d f", k), {28'd0, f_a}, {28'd0, tbl[k].f});
      cmp($sformatf("tbl%0d glitch", k), {28'd0, g_a}, {28'd0, tbl[k].g});
      cmp($sformatf("tbl%0d len", k), len_a, tbl[k].len);
      cmp($sformatf("tbl%0d any_f", k), {31'd0, any_a}, {31'd0, |tbl[k].f});
    end

    // saturation on the 3-bit counter instance
    for (int k = 0; k < 10; k++) step(4'b0100, 1'b0, "sat_model");
    step(4'b0000, 1'b0, "sat_model");
    step(4'b0000, 1'b0, "sat_model");
    cmp("sat f_b", {28'd0, f_b}, 32'h4);
    cmp("sat len_b ch2", {29'd0, len_b[8:6]}, 32'd7);
    cmp("sat len_a ch2", {24'd0, len_a[23:16]}, 32'd10);
    step(4'b0000, 1'b0, "sat_model");
    cmp("sat f_b single", {28'd0, f_b}, 32'h0);

    // asynchronous reset in the middle of a qualified run
    for (int k = 0; k < 4; k++) step(4'b0001, 1'b0, "arst_model");
    cmp("arst pre r_a", {28'd0, r_a}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("arst immediate");
    @(negedge clk);
    din = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 1'b0, "arst_model");
      cmp("arst no pulse", {24'd0, f_a, g_a}, 32'h0);
    end

    // random stimulus: levels flip with probability 1/4, rare clr
    lvl = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) lvl[c] = ~lvl[c];
      c_rand = ($urandom_range(0, 49) == 0);
      step(lvl, c_rand, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_tracker.md
Name: run_tracker

Overview:
- Multi-channel, parametrised run tracker with registered on-state outputs.
- Each channel watches one level input and reports its high runs: a level flag while a run is qualified, a one-cycle end-of-run pulse, and the captured run length.
- Runs shorter than MIN_RUN samples are rejected as glitches and flagged separately.
- Sits between raw status inputs and the event/interrupt logic that consumes run-end events.

Parameters:
- NCH, 4: number of independent channels, >= 1.
- CNT_W, 8: width of each channel's run-length counter and len field.
- MIN_RUN, 2: consecutive high samples needed to qualify a run; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of all channels; has priority over din.
- din  in  NCH  per-channel level input, sampled at every rising clk edge.
- r  out  NCH  per-channel run-active flag, registered.
- f  out  NCH  per-channel end-of-qualified-run pulse, registered, 1 cycle wide.
- glitch  out  NCH  per-channel rejected-run pulse, registered, 1 cycle wide.
- len  out  NCH*CNT_W  per-channel length of the last qualified run; channel i occupies bits [i*CNT_W +: CNT_W].
- any_f  out  1  combinational OR of f.

Behaviour:
- One clock (clk); rst is asynchronous, active-high. While rst is asserted:
  - every channel is forced to IDLE with cnt = 0;
  - r, f, glitch and len are all 0 immediately, without waiting for a clock edge.
- A reset asserted mid-run aborts that run silently; no f or glitch pulse follows.
- Each channel has an independent FSM (states IDLE, ARM, RUN, LAST, DROP; 3-bit encoding) and a saturating counter cnt[CNT_W-1:0].
- FSM transitions at each clk edge, for each channel i, when clr = 0:
  - IDLE, din=1: cnt <= 1; go to RUN if MIN_RUN == 1, otherwise ARM.
  - IDLE, din=0: stay in IDLE; cnt stays 0.
  - ARM, din=1: cnt <= cnt+1; go to RUN when cnt+1 >= MIN_RUN, otherwise stay in ARM.
  - ARM, din=0: go to DROP.
  - RUN, din=1: cnt <= cnt+1, saturating at 2^CNT_W-1 (no wrap); stay in RUN.
  - RUN, din=0: go to LAST; cnt is held.
  - LAST: go to IDLE unconditionally; cnt <= 0. The din sample taken in LAST is ignored, so a new run can start no earlier than the following edge.
  - DROP: go to IDLE unconditionally; cnt <= 0. The din sample taken in DROP is ignored.
  - Any unused encoding: go to IDLE, cnt <= 0.
- Outputs are registered on-state: at each edge, each output is loaded from the state held before that edge.
  - r[i] <= (state == RUN).
  - f[i] <= (state == LAST).
  - glitch[i] <= (state == DROP).
  - len[i] <= cnt when state == LAST; otherwise len[i] holds its value until the next LAST.
- Consequence: every output lags the FSM state by one cycle.
- clr = 1 at an edge, all channels:
  - state <= IDLE, cnt <= 0;
  - r, f, glitch <= 0;
  - len <= 0.
  - A run in progress is aborted with no f or glitch pulse.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- With MIN_RUN = 1: ARM and DROP are unreachable and glitch stays 0.

Test Plan:
- MIN_RUN=2; din[0] high for 5 samples (edges E0..E4), low at E5.
  - r[0] = 1 after edges E2..E5 (4 cycles).
  - f[0] = 1 for one cycle after E6, with len[0] = 5 from E6 onward.
  - any_f = 1 in the same cycle as f[0].
- MIN_RUN=2; din[1] high for 1 sample (E0), low at E1.
  - glitch[1] = 1 for one cycle after E2.
  - r[1], f[1] stay 0; len[1] unchanged.
- CNT_W=3; din[2] high for 10 samples, then low.
  - len[2] = 7 (saturated); f[2] pulses once.
- din[0] and din[3] high together for 3 samples, then low.
  - f[0] and f[3] pulse in the same cycle; both len fields = 3.
- din[0] high for 4 samples, clr at the 3rd edge.
  - At that edge, r[0] clears and len[0] = 0.
  - No f[0] or glitch[0] pulse follows.
  - The remaining high sample starts a new ARM (cnt = 1).
- During RUN (r[0] = 1), assert rst asynchronously between edges.
  - All outputs are 0 immediately.
  - After rst deasserts with din[0] = 0, no f or glitch pulse appears.
